// File: rtl/dat.sv
// rtl/dat.sv - accumulator datapath: A register, carry flag and small ALU
//
// Holds the accumulator (A) and carry flag (C) of the accumulator CPU core.
// The ALU combines A with the operand on data_i; the result is written back
// into A when ctr_a_reg_en_i is high. C is updated every cycle according to
// ctr_carrymux_i, regardless of the accumulator enable.
//
// Ports:
//   clk_i           in   clock, rising edge active
//   rst_i           in   synchronous active-high reset (A <= 0, C <= 0)
//   data_i          in   ALU operand (B side)
//   ctr_aluop_i     in   ALU operation select (OP_* codes below)
//   ctr_carrymux_i  in   carry next-value select (CARRY_OP_* codes below)
//   ctr_a_reg_en_i  in   accumulator write enable
//   carry_o         out  registered carry flag
//   data_o          out  registered accumulator value
module dat #(
  parameter int DATA_WIDTH         = 8,
  parameter int OP_WIDTH           = 2,
  parameter int CTR_CARRYMUX_WIDTH = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [DATA_WIDTH-1:0]         data_i,
  input  logic [OP_WIDTH-1:0]           ctr_aluop_i,
  input  logic [CTR_CARRYMUX_WIDTH-1:0] ctr_carrymux_i,
  input  logic                          ctr_a_reg_en_i,
  output logic                          carry_o,
  output logic [DATA_WIDTH-1:0]         data_o
);

  // ALU operation codes; any unlisted code loads data_i into A.
  localparam logic [OP_WIDTH-1:0] OP_ADD = 2'd0;
  localparam logic [OP_WIDTH-1:0] OP_NOR = 2'd1;
  localparam logic [OP_WIDTH-1:0] OP_JCC = 2'd2;

  // Carry next-value codes; any unlisted code holds C.
  localparam logic [CTR_CARRYMUX_WIDTH-1:0] CARRY_OP_GEN = 2'd0;
  localparam logic [CTR_CARRYMUX_WIDTH-1:0] CARRY_OP_CLR = 2'd1;
  localparam logic [CTR_CARRYMUX_WIDTH-1:0] CARRY_OP_SET = 2'd2;

  logic [DATA_WIDTH-1:0] acc;
  logic                  carry;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_carry;
  logic [DATA_WIDTH:0]   sum;

  // Plain add without carry-in; the extra MSB is the carry-out.
  assign sum = {1'b0, acc} + {1'b0, data_i};

  always_comb begin
    alu_result = data_i;
    alu_carry  = 1'b0;
    case (ctr_aluop_i)
      OP_ADD: begin
        alu_result = sum[DATA_WIDTH-1:0];
        alu_carry  = sum[DATA_WIDTH];
      end
      OP_NOR:  alu_result = ~(acc | data_i);
      OP_JCC:  alu_result = acc;
      default: alu_result = data_i;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc   <= '0;
      carry <= 1'b0;
    end else begin
      if (ctr_a_reg_en_i) begin
        acc <= alu_result;
      end
      // Carry follows the ALU even when A is not written, so a compare-like
      // ADD with the enable low still produces a flag.
      case (ctr_carrymux_i)
        CARRY_OP_GEN: carry <= alu_carry;
        CARRY_OP_CLR: carry <= 1'b0;
        CARRY_OP_SET: carry <= 1'b1;
        default:      carry <= carry;
      endcase
    end
  end

  assign data_o  = acc;
  assign carry_o = carry;

endmodule

// File: tb/tb_dat.sv
// tb/tb_dat.sv - self-checking bench for dat with a behavioural reference model
module tb_dat;

  localparam int DW = 8;

  localparam int OP_ADD  = 0;
  localparam int OP_NOR  = 1;
  localparam int OP_JCC  = 2;
  localparam int OP_LOAD = 3;

  localparam int C_GEN  = 0;
  localparam int C_CLR  = 1;
  localparam int C_SET  = 2;
  localparam int C_HOLD = 3;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic [DW-1:0] data_i = '0;
  logic [1:0]    ctr_aluop_i = '0;
  logic [1:0]    ctr_carrymux_i = '0;
  logic          ctr_a_reg_en_i = 1'b0;
  logic          carry_o;
  logic [DW-1:0] data_o;

  int n_checks = 0;
  int n_errors = 0;

  int unsigned m_a = 0;
  int unsigned m_c = 0;

  dat #(.DATA_WIDTH(DW)) u_dat (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .data_i         (data_i),
    .ctr_aluop_i    (ctr_aluop_i),
    .ctr_carrymux_i (ctr_carrymux_i),
    .ctr_a_reg_en_i (ctr_a_reg_en_i),
    .carry_o        (carry_o),
    .data_o         (data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of controls, advance the model by the spec rules, then
  // compare both outputs shortly after the edge.
  task automatic step(input int rst, input int op, input int cm, input int en,
                      input int unsigned d, input string tag);
    int unsigned r;
    int unsigned co;
    int unsigned mask;
    mask = (1 << DW) - 1;
    rst_i          = rst[0];
    ctr_aluop_i    = op[1:0];
    ctr_carrymux_i = cm[1:0];
    ctr_a_reg_en_i = en[0];
    data_i         = d[DW-1:0];
    co = 0;
    case (op)
      OP_ADD: begin
        r  = (m_a + d) % (1 << DW);
        co = (m_a + d) >= (1 << DW) ? 1 : 0;
      end
      OP_NOR:  r = ~(m_a | d) & mask;
      OP_JCC:  r = m_a;
      default: r = d;
    endcase
    @(posedge clk_i);
    if (rst != 0) begin
      m_a = 0;
      m_c = 0;
    end else begin
      if (en != 0) m_a = r;
      if (cm == C_GEN) m_c = co;
      else if (cm == C_CLR) m_c = 0;
      else if (cm == C_SET) m_c = 1;
    end
    #1;
    rst_i = 1'b0;
    check({tag, "_data"}, data_o, m_a);
    check({tag, "_carry"}, carry_o, m_c);
  endtask

  initial begin
    step(1, OP_ADD, C_GEN, 1, 0, "reset");
    check("reset_data_zero", data_o, 0);
    check("reset_carry_zero", carry_o, 0);

    for (int i = 0; i < 10; i++) step(0, OP_ADD, C_GEN, 1, 0, "add_zero");

    for (int i = 0; i < 10; i++) begin
      step(0, OP_ADD, C_GEN, 0, 'h59, "en_low");
      check("en_low_hold", data_o, 0);
    end

    for (int i = 1; i <= 256; i++) begin
      step(0, OP_ADD, C_GEN, 1, 1, "count");
      check("count_value", data_o, i % 256);
    end
    check("wrap_carry", carry_o, 1);

    step(0, OP_JCC, C_CLR, 0, $urandom_range(0, 255), "jcc_clr");
    check("jcc_clr_data", data_o, 0);
    check("jcc_clr_carry", carry_o, 0);

    step(0, OP_NOR, C_CLR, 1, 'h00, "nor0");
    check("nor0_ff", data_o, 'hff);
    step(0, OP_NOR, C_CLR, 1, 'hff, "nor1");
    check("nor1_zero", data_o, 0);

    step(0, OP_LOAD, C_SET, 1, 'h80, "load80");
    check("load80_data", data_o, 'h80);
    check("set_carry", carry_o, 1);
    step(0, OP_ADD, C_HOLD, 0, 'h7f, "hold");
    step(1, OP_ADD, C_GEN, 1, 'h80, "mid_reset");
    check("mid_reset_data", data_o, 0);

    step(0, OP_LOAD, C_GEN, 1, 'hff, "ld_ff");
    step(0, OP_ADD, C_GEN, 0, 'h02, "gen_en_low");
    check("gen_en_low_carry", carry_o, 1);
    check("gen_en_low_data", data_o, 'hff);

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 49) == 0) ? 1 : 0, $urandom_range(0, 3),
           $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 255), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dat.md
# dat

Accumulator datapath of the accumulator-based CPU core. It holds the accumulator register (A) and the carry flag, and combines A with an operand via a small ALU. It writes the result back into A under control-unit enables. It sits between the control unit, which drives the `ctr_*` inputs, and the memory/operand bus, which drives `data_i`. Its outputs feed memory writes and conditional-branch logic.

## Interface
Parameters:
- DATA_WIDTH, 8, width of the accumulator, operand and ALU.

Ports:
- Clocking: one clock; reset is synchronous and active-high.
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- data_i  in  DATA_WIDTH  operand (B side of the ALU).
- ctr_aluop_i  in  `OP_WIDTH  ALU operation select (`OP_*` codes from alpacacorn.vh).
- ctr_carrymux_i  in  `CTR_CARRYMUX_WIDTH  carry-flag next-value select (`CARRY_OP_*` codes from alpacacorn.vh).
- ctr_a_reg_en_i  in  1  accumulator write enable.
- carry_o  out  1  registered carry flag.
- data_o  out  DATA_WIDTH  registered accumulator value.

## Operation
- State: accumulator A[DATA_WIDTH-1:0] and carry flag C. `data_o` = A and `carry_o` = C, both driven directly from the registers with no combinational path from inputs.
- The ALU is purely combinational on A, `data_i` and `ctr_aluop_i`. It produces a result R[DATA_WIDTH-1:0] and a carry-out CO.
- `OP_ADD`: {CO, R} = A + `data_i`, zero-extended to DATA_WIDTH+1 bits. Plain add with no carry-in. Wraps modulo 2^DATA_WIDTH.
- `OP_NOR`: R = ~(A | `data_i`), CO = 0.
- `OP_JCC`: R = A (pass-through), CO = 0.
- Any other opcode: R = `data_i` (load), CO = 0.
- Accumulator: if `ctr_a_reg_en_i` = 1, A <= R; otherwise A holds. The value on `data_i` has no effect on A when the enable is low.
- Carry flag updates every cycle, independent of `ctr_a_reg_en_i`:
  - `CARRY_OP_GEN`: C <= CO.
  - `CARRY_OP_CLR`: C <= 0.
  - `CARRY_OP_SET`, if defined in the header: C <= 1.
  - Any other code: C holds.
- Reset (`rst_i` = 1 at a rising edge): A <= 0, C <= 0. Reset overrides all control inputs. Asserting it mid-operation discards the in-flight result on that edge.

## Timing
- Latency is one cycle: inputs sampled at rising edge N are visible on `data_o`/`carry_o` after edge N and stable before edge N+1.
- Outputs after reset: `data_o` = 0, `carry_o` = 0.
- Back-to-back operations are allowed every cycle. Each edge uses the current A, so a held ADD with `data_i` = 1 increments A once per clock.
- Wrap-around: A = 2^DATA_WIDTH-1 with ADD of 1 gives A = 0. With GEN on the same edge, C = 1.
- Enable low with GEN selected: C still takes CO computed from the current A and `data_i`, while A holds.

## Test plan
- Reset, then ADD with `data_i` = 0, enable = 1, GEN for 10 cycles -> `data_o` = 0x00 and `carry_o` = 0 every cycle.
- Enable = 0, `data_i` = 0x59, ADD/GEN for 10 cycles -> `data_o` stays 0x00, never 0x59.
- From A = 0: ADD with `data_i` = 0x01, enable = 1, GEN -> `data_o` = 1, 2, … 255 on successive edges. The 256th edge gives `data_o` = 0x00 and `carry_o` = 1.
- With C = 1: `OP_JCC`, `CARRY_OP_CLR`, enable = 0 for one edge -> `carry_o` = 0 and `data_o` unchanged.
- From A = 0x00: `OP_NOR` with `data_i` = 0x00, enable = 1 -> `data_o` = 0xFF. Next edge: NOR with `data_i` = 0xFF -> `data_o` = 0x00, and C stays 0 under CLR.
- Assert `rst_i` for one edge while an ADD is in progress with A = 0x80 and C = 1 -> `data_o` = 0x00 and `carry_o` = 0 after that edge.
